pipe_wf_stage: RTL and testbench
================================

// Module: pipe_wf_stage
// PURPOSE
//  Pipeline register between next-PC selection (write-back/PC-select side) and Fetch.
//  Captures the selected program counter on each rising CLK edge and presents it
//  to the Fetch stage as PC_F.
//  Supports stall (hold) and flush (bubble) so the hazard unit can control fetch.
//  Purely sequential boundary register; no arithmetic on the PC value.
// PARAMETERS
//  WIDTH     32          bit width of PC / PC_F
//  RST_PC    '0          PC_F value loaded on reset and on flush
// PORTS
//  CLK       input   1      single clock, rising-edge active
//  RST       input   1      synchronous reset, active-high
//  PC        input   WIDTH  next program counter from PC-select logic
//  STALL     input   1      1 = hold current PC_F/VALID_F (tie 0 if unused)
//  FLUSH     input   1      1 = inject bubble into Fetch (tie 0 if unused)
//  PC_F      output  WIDTH  registered PC delivered to Fetch
//  VALID_F   output  1      1 = PC_F holds a real fetch address, 0 = bubble
// BEHAVIOUR
//  - One clock, one reset. Reset is synchronous and active-high: sampled only at posedge CLK.
//  - All state updates on posedge CLK. Priority: RST > FLUSH > STALL > load.
//  - RST=1: PC_F <= RST_PC (0), VALID_F <= 0. Outputs remain so while RST is held.
//  - FLUSH=1 (RST=0): PC_F <= RST_PC, VALID_F <= 0. This overrides a simultaneous STALL.
//  - STALL=1 (RST=0, FLUSH=0): PC_F and VALID_F hold their previous values; PC is ignored.
//  - Otherwise: PC_F <= PC, VALID_F <= 1.
//  - Latency: exactly 1 cycle PC -> PC_F. No combinational path from any input to any output.
//  - Before the first reset edge, outputs are undefined (X in simulation).
//    Exception: the register initialises to RST_PC/0 where the technology supports initial values.
//  - PC is copied bit-exact; no wrap, increment or alignment checks (odd/unaligned values pass through).
//  - Asserting RST mid-stall or mid-flush discards the held value. First load after reset release occurs on the next edge with STALL=0.
//  - Changing PC between edges has no effect on PC_F until the next posedge.
// TESTING
//  - Reset: RST=1 for 2 edges with PC=32'hDEAD_BEEF -> PC_F=0, VALID_F=0 after each edge.
//  - Sequential load: RST=0, PC=0,4,8,12 on successive edges (10 ns clock period).
//    -> PC_F=0,4,8,12 one edge later each, VALID_F=1.
//  - Stall: PC_F=8, STALL=1 for 2 edges while PC=12,16 -> PC_F stays 8.
//    Release STALL with PC=16 -> PC_F=16 next edge.
//  - Flush: PC_F=12, FLUSH=1 with PC=20 -> PC_F=0, VALID_F=0.
//    Next edge with FLUSH=0, PC=24 -> PC_F=24, VALID_F=1.
//  - Priority: RST=1,FLUSH=1,STALL=1 -> reset values. FLUSH=1,STALL=1 -> bubble (PC_F=0, VALID_F=0).
//  - Width: WIDTH=16, PC=16'hFFFF -> PC_F=16'hFFFF. Mid-cycle PC glitch does not alter PC_F.

Source files
------------

// File: rtl/pipe_wf_stage_if.sv
// Handshake bundle between PC-select and Fetch.
// The master drives the next PC and hazard controls, and the slave returns the fetch PC.
interface pipe_wf_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] PC;
    logic             STALL;
    logic             FLUSH;
    logic [WIDTH-1:0] PC_F;
    logic             VALID_F;

    modport master (
        output PC,
        output STALL,
        output FLUSH,
        input  PC_F,
        input  VALID_F
    );

    modport slave (
        input  PC,
        input  STALL,
        input  FLUSH,
        output PC_F,
        output VALID_F
    );
endinterface

// File: rtl/pipe_wf_stage.sv
// Pipeline register from next-PC selection into Fetch.
// It supports a stall that holds the current PC and a flush that inserts a bubble.
module pipe_wf_stage #(
    parameter int             WIDTH  = 32,
    parameter logic [WIDTH-1:0] RST_PC = '0
) (
    input logic            CLK,
    input logic            RST,
    pipe_wf_stage_if.slave wf
);
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic             valid_d;
    logic             valid_q;

    // Flush outranks stall; a stalled cycle keeps the held value.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        if (wf.FLUSH) begin
            pc_d    = RST_PC;
            valid_d = 1'b0;
        end else if (!wf.STALL) begin
            pc_d    = wf.PC;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= RST_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign wf.PC_F    = pc_q;
    assign wf.VALID_F = valid_q;
endmodule

// File: tb/tb_pipe_wf_stage.sv
// Self-checking bench for pipe_wf_stage at WIDTH 32 and 16.
// It uses a behavioural fetch-PC model together with directed literal checks.
module tb_pipe_wf_stage;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    pipe_wf_stage_if #(.WIDTH(32)) w32 ();
    pipe_wf_stage_if #(.WIDTH(16)) w16 ();

    assign w16.STALL = w32.STALL;
    assign w16.FLUSH = w32.FLUSH;

    pipe_wf_stage #(.WIDTH(32)) dut32 (
        .CLK(CLK),
        .RST(RST),
        .wf (w32.slave)
    );

    pipe_wf_stage #(.WIDTH(16)) dut16 (
        .CLK(CLK),
        .RST(RST),
        .wf (w16.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what Fetch must see after each edge.
    logic [31:0] m_pc32;
    logic [15:0] m_pc16;
    logic        m_v32;
    logic        m_v16;
    bit          known = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_pc32 = 32'h0;
            m_v32  = 1'b0;
            m_pc16 = 16'h0;
            m_v16  = 1'b0;
            known  = 1;
        end else if (known) begin
            if (w32.FLUSH) begin
                m_pc32 = 32'h0;
                m_v32  = 1'b0;
                m_pc16 = 16'h0;
                m_v16  = 1'b0;
            end else if (!w32.STALL) begin
                m_pc32 = w32.PC;
                m_v32  = 1'b1;
                m_pc16 = w16.PC;
                m_v16  = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (known) begin
            chk("model_pc32", w32.PC_F, m_pc32);
            chk("model_v32", {31'h0, w32.VALID_F}, {31'h0, m_v32});
            chk("model_pc16", {16'h0, w16.PC_F}, {16'h0, m_pc16});
            chk("model_v16", {31'h0, w16.VALID_F}, {31'h0, m_v16});
        end
    end

    task automatic drive(input logic r, input logic f, input logic s,
                         input logic [31:0] pc);
        RST       = r;
        w32.FLUSH = f;
        w32.STALL = s;
        w32.PC    = pc;
        w16.PC    = pc[15:0];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect32(input string name, input logic [31:0] pc,
                            input logic v);
        chk({name, "_pc"}, w32.PC_F, pc);
        chk({name, "_valid"}, {31'h0, w32.VALID_F}, {31'h0, v});
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();
        expect32("reset1", 32'h0, 1'b0);
        tick();
        expect32("reset2", 32'h0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        expect32("load0", 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h4);
        tick();
        expect32("load4", 32'h4, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h8);
        tick();
        expect32("load8", 32'h8, 1'b1);

        drive(1'b0, 1'b0, 1'b1, 32'hC);
        tick();
        expect32("stall1", 32'h8, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h10);
        tick();
        expect32("stall2", 32'h8, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h10);
        tick();
        expect32("unstall", 32'h10, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 32'hC);
        tick();
        expect32("load12", 32'hC, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h14);
        tick();
        expect32("flush", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h18);
        tick();
        expect32("postflush", 32'h18, 1'b1);

        drive(1'b1, 1'b1, 1'b1, 32'h55);
        tick();
        expect32("prio_rst", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h77);
        tick();
        expect32("load77", 32'h77, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h99);
        tick();
        expect32("prio_flush", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h9C);
        tick();
        expect32("stall_bubble", 32'h0, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 32'h100);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        tick();
        expect32("rst_midstall", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        expect32("stall_after_rst", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h104);
        tick();
        expect32("first_load", 32'h104, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick();
        expect32("all_ones", 32'hFFFF_FFFF, 1'b1);
        chk("w16_ffff", {16'h0, w16.PC_F}, 32'h0000_FFFF);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_1235);
        #3;
        chk("glitch32", w32.PC_F, 32'hFFFF_FFFF);
        chk("glitch16", {16'h0, w16.PC_F}, 32'h0000_FFFF);
        tick();
        expect32("odd_pc", 32'h0000_1235, 1'b1);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom);
            tick();
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
